bcd_to_binary_seq: RTL and testbench



---
 rtl/bcd_conv_pkg.sv | 21 ++
 rtl/sub3.sv | 16 +
 rtl/bcd_to_binary_seq.sv | 124 ++++++++++++
 tb/tb_bcd_to_binary_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_conv_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_conv_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   // Number of shift/correct iterations for an 8-bit binary result.
   localparam int unsigned N_STEPS   = 8;

   // Working register layout: {hund[1:0], tens[3:0], ones[3:0], bin[7:0]}.
   localparam int unsigned WORK_W    = 18;
   localparam int unsigned HUND_LSB  = 16;
   localparam int unsigned TENS_LSB  = 12;
   localparam int unsigned ONES_LSB  = 8;

   // Largest legal decimal digit.
   localparam logic [3:0]  DIGIT_MAX = 4'd9;

endpackage

// File: rtl/sub3.sv
// Single-digit corrector for reverse double-dabble: subtract 3 when the
// digit is 8 or more after a right shift, otherwise pass it through.
module sub3 (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   // Combinational correction of one BCD digit.
   always_comb begin
      dout = din;
      if (din >= 4'd8) begin
         dout = din - 4'd3;
      end
   end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential three-digit BCD-to-binary converter with start/done handshake.
// Each step shifts the working register right by one and then corrects the
// tens and ones digits; after eight steps the low byte holds the binary value
// and any bits left in the BCD part mean the value exceeded 255.
module bcd_to_binary_seq
   import bcd_conv_pkg::*;
(
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       start,
   input  logic [9:0] bcd_in,
   output logic       busy,
   output logic       done,
   output logic [7:0] bin_out,
   output logic       err
);

   localparam logic [2:0] LAST_STEP = 3'(N_STEPS - 1);

   state_t              state_q, state_d;
   logic [2:0]          cnt_q,   cnt_d;
   logic [WORK_W-1:0]   work_q,  work_d;
   logic                busy_q,  busy_d;
   logic                done_q,  done_d;
   logic [7:0]          bin_q,   bin_d;
   logic                err_q,   err_d;

   logic [WORK_W-1:0]   shifted;
   logic [WORK_W-1:0]   stepped;
   logic [3:0]          tens_fix;
   logic [3:0]          ones_fix;
   logic                digit_bad;

   // Shift first; the digit correction below operates on the shifted value.
   assign shifted = work_q >> 1;

   sub3 u_sub3_tens (
      .din  (shifted[TENS_LSB +: 4]),
      .dout (tens_fix)
   );

   sub3 u_sub3_ones (
      .din  (shifted[ONES_LSB +: 4]),
      .dout (ones_fix)
   );

   // Reassemble one full step: hundreds never needs correction (always < 8).
   assign stepped = {shifted[WORK_W-1:HUND_LSB], tens_fix, ones_fix,
                     shifted[ONES_LSB-1:0]};

   assign digit_bad = (bcd_in[7:4] > DIGIT_MAX) || (bcd_in[3:0] > DIGIT_MAX);

   // Next-state, datapath and registered-output logic of the FSM.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      bin_d   = bin_q;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (digit_bad) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
                  bin_d  = '0;
               end else begin
                  work_d  = {bcd_in, 8'h00};
                  cnt_d   = '0;
                  busy_d  = 1'b1;
                  state_d = CONV;
               end
            end
         end

         CONV: begin
            work_d = stepped;
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q == LAST_STEP) begin
               bin_d   = stepped[7:0];
               err_d   = |stepped[WORK_W-1:ONES_LSB];
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         bin_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         bin_q   <= bin_d;
         err_q   <= err_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign bin_out = bin_q;
   assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed and randomized bench for bcd_to_binary_seq. Expected results come
// from decimal arithmetic on the three digits.
module tb_bcd_to_binary_seq;

   logic       clk;
   logic       reset;
   logic       start;
   logic [9:0] bcd_in;
   logic       busy;
   logic       done;
   logic [7:0] bin_out;
   logic       err;

   int passed;
   int total;

   logic [7:0] last_bin;
   logic       last_err;

   bcd_to_binary_seq dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .start    (start),
      .bcd_in   (bcd_in),
      .busy     (busy),
      .done     (done),
      .bin_out  (bin_out),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference: decimal value of the digits; bad digits give err with zero.
   function automatic void model(input logic [9:0] v, output logic [7:0] b,
                                 output logic e, output logic bad);
      int unsigned h, t, o, val;
      h = v[9:8];
      t = v[7:4];
      o = v[3:0];
      bad = (t > 9) || (o > 9);
      if (bad) begin
         b = 8'h00;
         e = 1'b1;
      end else begin
         val = h * 100 + t * 10 + o;
         b = 8'(val % 256);
         e = (val > 255);
      end
   endfunction

   function automatic logic [9:0] mk(input int unsigned h, input int unsigned t,
                                     input int unsigned o);
      return {2'(h), 4'(t), 4'(o)};
   endfunction

   // One full conversion with cycle-exact checks of busy/done/bin_out/err.
   task automatic conv(input logic [9:0] v, input string tag);
      logic [7:0] b;
      logic       e, bad;
      model(v, b, e, bad);
      @(negedge clk);
      bcd_in = v;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      bcd_in = 10'($urandom);
      if (bad) begin
         chk({tag, "_done"}, 32'(done), 32'(1'b1));
         chk({tag, "_err"},  32'(err),  32'(1'b1));
         chk({tag, "_bin"},  32'(bin_out), 32'(8'h00));
         chk({tag, "_busy"}, 32'(busy), 32'(1'b0));
      end else begin
         chk({tag, "_busy0"}, 32'({busy, done}), 32'(2'b10));
         for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            chk({tag, "_run"}, 32'({busy, done, bin_out, err}),
                32'({1'b1, 1'b0, last_bin, last_err}));
         end
         @(negedge clk);
         chk({tag, "_done"}, 32'({busy, done}), 32'(2'b01));
         chk({tag, "_bin"},  32'(bin_out), 32'(b));
         chk({tag, "_err"},  32'(err), 32'(e));
      end
      last_bin = b;
      last_err = e;
      @(negedge clk);
      chk({tag, "_after"}, 32'({busy, done}), 32'(2'b00));
   endtask

   initial begin
      logic [7:0] b, b2;
      logic       e, e2, bad;
      logic       saw_done;
      int unsigned h, t, o;

      passed = 0;
      total  = 0;
      reset  = 1'b1;
      start  = 1'b0;
      bcd_in = '0;
      repeat (2) @(negedge clk);
      chk("reset", 32'({busy, done, err, bin_out}), 32'(11'h000));
      reset = 1'b0;
      last_bin = 8'h00;
      last_err = 1'b0;

      conv(mk(2, 5, 5), "v255");
      conv(mk(0, 4, 2), "v042");
      conv(mk(0, 0, 0), "v000");
      conv(mk(3, 0, 0), "v300");
      conv(mk(2, 5, 6), "v256");
      conv(mk(1, 9, 9), "v199");
      conv(mk(0, 10, 3), "badA3");
      conv(mk(0, 2, 15), "badF");

      // 123 with extra start pulses sampled at steps 3 and 5.
      @(negedge clk);
      bcd_in = mk(1, 2, 3);
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         start = (i == 2 || i == 4);
         chk("p123_run", 32'({busy, done}), 32'(2'b10));
      end
      @(negedge clk);
      start = 1'b0;
      chk("p123_done", 32'({busy, done, bin_out, err}), 32'({2'b01, 8'h7B, 1'b0}));
      @(negedge clk);
      chk("p123_single", 32'({busy, done}), 32'(2'b00));

      // start held high: a second conversion is accepted on the done cycle.
      model(mk(0, 6, 4), b, e, bad);
      model(mk(2, 1, 8), b2, e2, bad);
      @(negedge clk);
      bcd_in = mk(0, 6, 4);
      start  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("hold_run1", 32'({busy, done}), 32'(2'b10));
      end
      @(negedge clk);
      bcd_in = mk(2, 1, 8);
      chk("hold_done1", 32'({busy, done, bin_out, err}), 32'({2'b01, b, e}));
      @(negedge clk);
      start = 1'b0;
      chk("hold_restart", 32'({busy, done}), 32'(2'b10));
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         chk("hold_run2", 32'({busy, done}), 32'(2'b10));
      end
      @(negedge clk);
      chk("hold_done2", 32'({busy, done, bin_out, err}), 32'({2'b01, b2, e2}));
      @(negedge clk);
      last_bin = b2;
      last_err = e2;

      // Reset during step 4 aborts the conversion.
      bcd_in = mk(1, 5, 0);
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort", 32'({busy, done, err, bin_out}), 32'(11'h000));
      saw_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         saw_done = saw_done | done | busy;
      end
      chk("abort_quiet", 32'(saw_done), 32'(1'b0));
      last_bin = 8'h00;
      last_err = 1'b0;
      conv(mk(0, 7, 7), "v077");

      // Randomized conversions, occasionally with an illegal digit.
      for (int n = 0; n < 24; n++) begin
         h = $urandom_range(0, 3);
         t = $urandom_range(0, 9);
         o = $urandom_range(0, 9);
         if (n % 6 == 5) begin
            if (n % 12 == 5) t = $urandom_range(10, 15);
            else o = $urandom_range(10, 15);
         end
         conv(mk(h, t, o), "rand");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
